rib_mem_arbiter: RTL and testbench
==================================

// Module: rib_mem_arbiter
// PURPOSE
// Shares one memory/peripheral slave port between three masters: JTAG debug (m0), core EX load/store (m1) and core instruction fetch (m2).
// Each transaction has an address phase (req/gnt) and a response phase (rvalid).
// Transactions are serialised: exactly one is outstanding at a time.
// Drives the core bus-stall flag, bounds slave latency with a timeout, and keeps fetch from starving under load/store traffic.
// PARAMETERS
// ADDR_W      32   address width, all ports
// DATA_W      32   data width, all ports
// STARVE_MAX  8    consecutive m1 grants with m2 pending before m2 is promoted (range 1..255)
// TIMEOUT     255  cycles a transaction may remain in ADDR+RESP before abort (range 2..65535)
// PORTS
// clk           in   1       clock
// rst           in   1       synchronous reset, active low
// mN_req        in   1       master N request (N=0,1,2); held high until mN_gnt
// mN_we         in   1       master N write enable
// mN_addr       in   ADDR_W  master N address
// mN_wdata      in   DATA_W  master N write data
// mN_gnt        out  1       one-cycle pulse: master N request captured
// mN_rvalid     out  1       one-cycle pulse: master N response complete
// mN_rdata      out  DATA_W  master N read data; valid only with mN_rvalid
// s_req         out  1       slave request
// s_we          out  1       slave write enable
// s_addr        out  ADDR_W  slave address
// s_wdata       out  DATA_W  slave write data
// s_gnt         in   1       slave accepts address phase
// s_rvalid      in   1       slave response valid
// s_rdata       in   DATA_W  slave read data
// hold_flag_o   out  1       stall request to core ctrl
// bus_err_o     out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE, owner=none, starve_cnt=0, to_cnt=0, captured addr/we/wdata=0.
//   All outputs 0. Any in-flight transaction is dropped; no rvalid is ever issued for it.
// - FSM states IDLE / ADDR / RESP.
// - IDLE, some mN_req=1:
//   - Pick winner; pulse mN_gnt the same cycle.
//   - Register owner, mN_addr, mN_we, mN_wdata.
//   - Next state ADDR.
// - ADDR:
//   - s_req=1; s_addr/s_we/s_wdata come from the registered copy (stable while s_req=1).
//   - s_gnt=1 -> RESP; s_req is deasserted the following cycle.
// - RESP, s_rvalid=1:
//   - mOwner_rvalid=1 and mOwner_rdata=s_rdata in the same cycle (combinational pass-through).
//   - Other masters' rdata=0.
//   - If any mN_req=1, arbitrate in this cycle (gnt pulse, capture) and go to ADDR. Otherwise go to IDLE.
// - Best-case throughput: one transaction per 2 cycles (s_gnt and s_rvalid each in their first cycle).
// - Priority:
//   - m0 > m1 > m2 by default.
//   - When starve_cnt==STARVE_MAX and m2_req=1, order is m0 > m2 > m1.
// - starve_cnt (8 bit):
//   - +1 on each m1 grant while m2_req=1.
//   - Cleared on an m2 grant, or on any cycle with m2_req=0.
//   - Saturates at STARVE_MAX.
// - Timeout, to_cnt (16 bit):
//   - Cleared on entry to ADDR; increments every cycle in ADDR or RESP.
//   - At to_cnt==TIMEOUT-1 with no s_rvalid: pulse mOwner_rvalid with rdata=0, pulse bus_err_o, s_req=0, go IDLE.
//   - s_rvalid and timeout in the same cycle: the response wins; no error.
// - s_rvalid in IDLE or ADDR and s_gnt outside ADDR are ignored. No state change.
// - hold_flag_o=1 in any of these cases:
//   - m1_req=1 or m2_req=1 without mN_gnt this cycle.
//   - owner is m1 or m2 and its rvalid is not yet returned.
//   - owner is m0 (not IDLE).
//   - It drops in the cycle mN_rvalid pulses if no other request is pending.
// - m0 is not stalled by hold_flag_o; its handshake is independent.
// TESTING
// 1. Reset: rst=0 for 3 cycles with all reqs=1 -> every output 0. After rst=1, m0_gnt pulses first.
// 2. Single read: m1 read addr 0x1000_0004; slave gnt in cycle 1, rvalid with 0xDEAD_BEEF in cycle 2
//    -> s_addr=0x1000_0004, m1_rvalid=1 with m1_rdata=0xDEAD_BEEF, hold_flag_o low the next cycle.
// 3. Contention: m0, m1, m2 all request together -> grant order m0, m1, m2. Back-to-back transactions 2 cycles apart.
// 4. Starvation: m1 requests continuously, m2 pending, STARVE_MAX=8 -> 8 m1 grants, then m2 granted, starve_cnt=0.
// 5. Timeout: TIMEOUT=16, slave never asserts rvalid -> owner's rvalid and bus_err_o both pulse 16 cycles after ADDR entry;
//    rdata=0; then IDLE.
// 6. Mid-op reset: rst=0 while in RESP, then slave rvalid -> no mN_rvalid; state IDLE; next request proceeds normally.

Source files
------------

// File: rtl/rib_mem_arbiter.sv
// Shares one req/gnt + rvalid slave port between JTAG (m0), load/store (m1) and fetch (m2).
// One transaction in flight; includes fetch anti-starvation, slave timeout abort and the core stall flag.
module rib_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              m2_req,
   input  logic              m2_we,
   input  logic [ADDR_W-1:0] m2_addr,
   input  logic [DATA_W-1:0] m2_wdata,
   output logic              m2_gnt,
   output logic              m2_rvalid,
   output logic [DATA_W-1:0] m2_rdata,
   output logic              s_req,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic              s_gnt,
   input  logic              s_rvalid,
   input  logic [DATA_W-1:0] s_rdata,
   output logic              hold_flag_o,
   output logic              bus_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0]  OWN_M0     = 2'd0;
   localparam logic [1:0]  OWN_M1     = 2'd1;
   localparam logic [1:0]  OWN_M2     = 2'd2;
   localparam logic [1:0]  OWN_NONE   = 2'd3;
   localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [7:0]        starve_q, starve_d;
   logic [15:0]       to_q, to_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic       run;
   logic       any_req;
   logic       resp_done;
   logic       timeout;
   logic       xfer_end;
   logic       grant;
   logic       promote;
   logic [1:0] winner;

   // A new transaction may start from IDLE or in the very cycle the previous response lands.
   always_comb begin
      run       = rst;
      any_req   = m0_req | m1_req | m2_req;
      resp_done = run && (state_q == ST_RESP) && s_rvalid;
      timeout   = run && (to_q == TO_LAST) &&
                  ((state_q == ST_ADDR) || ((state_q == ST_RESP) && !s_rvalid));
      xfer_end  = resp_done || timeout;
      grant     = run && any_req && ((state_q == ST_IDLE) || resp_done);
      promote   = (starve_q == STARVE_LIM) && m2_req;
      winner    = OWN_NONE;
      if (m0_req)       winner = OWN_M0;
      else if (promote) winner = OWN_M2;
      else if (m1_req)  winner = OWN_M1;
      else if (m2_req)  winner = OWN_M2;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      to_d     = to_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      case (state_q)
         ST_IDLE: ;
         ST_ADDR: begin
            to_d = to_q + 16'd1;
            if (timeout) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
            end else if (s_gnt) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            to_d = to_q + 16'd1;
            if (xfer_end) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
      if (grant) begin
         state_d = ST_ADDR;
         owner_d = winner;
         to_d    = 16'd0;
         case (winner)
            OWN_M0: begin
               addr_d  = m0_addr;
               we_d    = m0_we;
               wdata_d = m0_wdata;
            end
            OWN_M1: begin
               addr_d  = m1_addr;
               we_d    = m1_we;
               wdata_d = m1_wdata;
            end
            default: begin
               addr_d  = m2_addr;
               we_d    = m2_we;
               wdata_d = m2_wdata;
            end
         endcase
      end
      // Fetch starvation only accumulates while fetch is actually waiting.
      if (!m2_req || (grant && (winner == OWN_M2))) begin
         starve_d = 8'd0;
      end else if (grant && (winner == OWN_M1) && (starve_q < STARVE_LIM)) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_comb begin
      m0_gnt      = grant && (winner == OWN_M0);
      m1_gnt      = grant && (winner == OWN_M1);
      m2_gnt      = grant && (winner == OWN_M2);
      m0_rvalid   = xfer_end && (owner_q == OWN_M0);
      m1_rvalid   = xfer_end && (owner_q == OWN_M1);
      m2_rvalid   = xfer_end && (owner_q == OWN_M2);
      m0_rdata    = (resp_done && (owner_q == OWN_M0)) ? s_rdata : '0;
      m1_rdata    = (resp_done && (owner_q == OWN_M1)) ? s_rdata : '0;
      m2_rdata    = (resp_done && (owner_q == OWN_M2)) ? s_rdata : '0;
      s_req       = run && (state_q == ST_ADDR) && !timeout;
      s_we        = s_req && we_q;
      s_addr      = s_req ? addr_q : '0;
      s_wdata     = s_req ? wdata_q : '0;
      bus_err_o   = timeout;
      hold_flag_o = run && ((m1_req && !(grant && (winner == OWN_M1))) ||
                            (m2_req && !(grant && (winner == OWN_M2))) ||
                            ((state_q != ST_IDLE) && !xfer_end) ||
                            (xfer_end && any_req));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_NONE;
         starve_q <= 8'd0;
         to_q     <= 16'd0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         to_q     <= to_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
      end
   end

endmodule

// File: tb/tb_rib_mem_arbiter.sv
// Bench for rib_mem_arbiter: vector table, directed multi-cycle sequences, then random traffic
// checked against a transaction-level reference model.
module tb_rib_mem_arbiter;

   localparam int SMAX = 8;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a   [3];
   logic        we_a    [3];
   logic [31:0] addr_a  [3];
   logic [31:0] wdata_a [3];
   logic        m0_gnt, m1_gnt, m2_gnt, m0_rvalid, m1_rvalid, m2_rvalid;
   logic [31:0] m0_rdata, m1_rdata, m2_rdata;
   logic        s_req, s_we, s_gnt, s_rvalid, hold_flag_o, bus_err_o;
   logic [31:0] s_addr, s_wdata, s_rdata;

   always #5 clk = ~clk;

   rib_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req_a[0]), .m0_we(we_a[0]), .m0_addr(addr_a[0]), .m0_wdata(wdata_a[0]),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(req_a[1]), .m1_we(we_a[1]), .m1_addr(addr_a[1]), .m1_wdata(wdata_a[1]),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .m2_req(req_a[2]), .m2_we(we_a[2]), .m2_addr(addr_a[2]), .m2_wdata(wdata_a[2]),
      .m2_gnt(m2_gnt), .m2_rvalid(m2_rvalid), .m2_rdata(m2_rdata),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o)
   );

   logic [2:0]  gnt_v, rv_v;
   logic [31:0] rd_v [3];
   logic        any_out;
   assign gnt_v   = {m2_gnt, m1_gnt, m0_gnt};
   assign rv_v    = {m2_rvalid, m1_rvalid, m0_rvalid};
   assign rd_v[0] = m0_rdata;
   assign rd_v[1] = m1_rdata;
   assign rd_v[2] = m2_rdata;
   assign any_out = |{gnt_v, rv_v, m0_rdata, m1_rdata, m2_rdata, s_req, s_we, s_addr, s_wdata,
                      hold_flag_o, bus_err_o};

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [2:0]  exp_gnt;
   } vec_t;

   vec_t        vt [8];
   logic [2:0]  c_gnt [7];
   logic [2:0]  c_rv  [7];
   int          w, cnt, m2g, cyc, early;
   logic [2:0]  gseen;

   // reference model state: one outstanding transaction at most
   bit          mb_busy, mb_acc;
   int          mb_age, mb_owner, mb_starve;
   logic [31:0] mb_addr, mb_wdata;
   logic        mb_we;
   bit          dead;

   task automatic model_cycle();
      bit [2:0]    rq;
      bit          in_addr, done, tmo, free;
      int          win;
      logic [2:0]  e_gnt, e_rv;
      logic [31:0] e_rd [3];
      logic        e_sreq, e_err, e_hold;
      rq      = {req_a[2], req_a[1], req_a[0]};
      in_addr = mb_busy && !mb_acc;
      done    = mb_busy && mb_acc && s_rvalid;
      tmo     = mb_busy && (mb_age == TMO - 1) && !done;
      free    = !mb_busy || done;
      win     = -1;
      if (free && rq != 3'b000) begin
         if (rq[0])                            win = 0;
         else if (mb_starve == SMAX && rq[2])  win = 2;
         else if (rq[1])                       win = 1;
         else                                  win = 2;
      end
      e_gnt = 3'b000;
      e_rv  = 3'b000;
      for (int n = 0; n < 3; n++) e_rd[n] = 32'h0;
      if (win >= 0) e_gnt[win] = 1'b1;
      if (done || tmo) e_rv[mb_owner] = 1'b1;
      if (done) e_rd[mb_owner] = s_rdata;
      e_sreq = in_addr && !tmo;
      e_err  = tmo;
      e_hold = (rq[1] && win != 1) || (rq[2] && win != 2) ||
               (mb_busy && !(done || tmo)) || ((done || tmo) && rq != 3'b000);
      if (!rst) begin
         e_gnt = 3'b000; e_rv = 3'b000; e_sreq = 1'b0; e_err = 1'b0; e_hold = 1'b0;
         for (int n = 0; n < 3; n++) e_rd[n] = 32'h0;
      end
      chk("rnd_gnt", 32'(gnt_v), 32'(e_gnt));
      chk("rnd_rvalid", 32'(rv_v), 32'(e_rv));
      for (int n = 0; n < 3; n++) chk("rnd_rdata", rd_v[n], e_rd[n]);
      chk("rnd_sreq", 32'(s_req), 32'(e_sreq));
      if (e_sreq) begin
         chk("rnd_saddr", s_addr, mb_addr);
         chk("rnd_swe", 32'(s_we), 32'(mb_we));
         chk("rnd_swdata", s_wdata, mb_wdata);
      end
      chk("rnd_buserr", 32'(bus_err_o), 32'(e_err));
      chk("rnd_hold", 32'(hold_flag_o), 32'(e_hold));
      if (!rst) begin
         mb_busy = 0; mb_acc = 0; mb_age = 0; mb_starve = 0;
      end else begin
         if (done || tmo) mb_busy = 0;
         else if (in_addr && s_gnt) mb_acc = 1;
         if (mb_busy) mb_age++;
         if (!rq[2] || win == 2) mb_starve = 0;
         else if (win == 1 && mb_starve < SMAX) mb_starve++;
         if (win >= 0) begin
            mb_busy  = 1; mb_acc = 0; mb_age = 0; mb_owner = win;
            mb_addr  = addr_a[win];
            mb_we    = we_a[win];
            mb_wdata = wdata_a[win];
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0] = '{3'b010, 1'b0, 32'h1000_0004, 32'h0000_0000, 32'hDEAD_BEEF, 3'b010};
      vt[1] = '{3'b001, 1'b1, 32'h2000_0000, 32'h1234_5678, 32'h0000_0000, 3'b001};
      vt[2] = '{3'b100, 1'b0, 32'h3000_0010, 32'h0000_0000, 32'hCAFE_F00D, 3'b100};
      vt[3] = '{3'b111, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 32'h1111_2222, 3'b001};
      vt[4] = '{3'b110, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h8765_4321, 3'b010};
      vt[5] = '{3'b101, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, 3'b001};
      vt[6] = '{3'b011, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'h7FFF_FFFF, 3'b001};
      vt[7] = '{3'b100, 1'b1, 32'h0000_0008, 32'hFFFF_0000, 32'h0000_0001, 3'b100};
      c_gnt[0] = 3'b001; c_gnt[1] = 3'b000; c_gnt[2] = 3'b010; c_gnt[3] = 3'b000;
      c_gnt[4] = 3'b100; c_gnt[5] = 3'b000; c_gnt[6] = 3'b000;
      c_rv[0]  = 3'b000; c_rv[1]  = 3'b000; c_rv[2]  = 3'b001; c_rv[3]  = 3'b000;
      c_rv[4]  = 3'b010; c_rv[5]  = 3'b000; c_rv[6]  = 3'b100;

      // reset with every request and slave strobe asserted
      rst = 1'b0; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5A5A_0F0F;
      for (int n = 0; n < 3; n++) begin
         req_a[n] = 1'b1; we_a[n] = 1'b1; addr_a[n] = 32'h100 * n; wdata_a[n] = 32'hF0 + n;
      end
      repeat (3) begin
         tick();
         @(negedge clk);
         chk("reset_outputs_zero", 32'(any_out), 32'h0);
      end
      tick();
      rst = 1'b1; s_gnt = 1'b0; s_rvalid = 1'b0;
      @(negedge clk);
      chk("reset_first_gnt", 32'(gnt_v), 32'(3'b001));
      tick();
      for (int n = 0; n < 3; n++) req_a[n] = 1'b0;
      s_gnt = 1'b1;
      tick();
      s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("reset_m0_rvalid", 32'(rv_v), 32'(3'b001));
      chk("reset_m0_rdata", m0_rdata, 32'h0BAD_F00D);
      tick();
      s_rvalid = 1'b0;

      // single-transaction vectors from IDLE
      for (int i = 0; i < 8; i++) begin
         w = vt[i].exp_gnt[1] ? 1 : (vt[i].exp_gnt[2] ? 2 : 0);
         for (int n = 0; n < 3; n++) begin
            req_a[n]   = vt[i].req[n];
            we_a[n]    = (n == w) ? vt[i].we : ~vt[i].we;
            addr_a[n]  = (n == w) ? vt[i].addr : ~vt[i].addr;
            wdata_a[n] = (n == w) ? vt[i].wdata : ~vt[i].wdata;
         end
         @(negedge clk);
         chk("tbl_gnt", 32'(gnt_v), 32'(vt[i].exp_gnt));
         chk("tbl_hold_arb", 32'(hold_flag_o),
             32'((vt[i].req[1] && !vt[i].exp_gnt[1]) || (vt[i].req[2] && !vt[i].exp_gnt[2])));
         tick();
         for (int n = 0; n < 3; n++) req_a[n] = 1'b0;
         s_gnt = 1'b1;
         @(negedge clk);
         chk("tbl_sreq", 32'(s_req), 32'h1);
         chk("tbl_saddr", s_addr, vt[i].addr);
         chk("tbl_swe", 32'(s_we), 32'(vt[i].we));
         chk("tbl_swdata", s_wdata, vt[i].wdata);
         chk("tbl_hold_busy", 32'(hold_flag_o), 32'h1);
         tick();
         s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = vt[i].rdata;
         @(negedge clk);
         chk("tbl_rvalid", 32'(rv_v), 32'(vt[i].exp_gnt));
         chk("tbl_rdata", rd_v[w], vt[i].rdata);
         chk("tbl_rdata_others", rd_v[(w + 1) % 3] | rd_v[(w + 2) % 3], 32'h0);
         chk("tbl_sreq_resp", 32'(s_req), 32'h0);
         chk("tbl_hold_done", 32'(hold_flag_o), 32'h0);
         tick();
         s_rvalid = 1'b0; s_rdata = 32'h3C3C_3C3C;
         @(negedge clk);
         chk("tbl_idle_rvalid", 32'(rv_v), 32'h0);
         chk("tbl_idle_hold", 32'(hold_flag_o), 32'h0);
         tick();
      end

      // contention: all masters at once, best-case slave
      for (int n = 0; n < 3; n++) req_a[n] = 1'b1;
      s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_0777;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("cont_gnt", 32'(gnt_v), 32'(c_gnt[k]));
         chk("cont_rvalid", 32'(rv_v), 32'(c_rv[k]));
         gseen = gnt_v;
         tick();
         for (int n = 0; n < 3; n++) if (gseen[n]) req_a[n] = 1'b0;
      end
      s_gnt = 1'b0; s_rvalid = 1'b0;

      // starvation: m1 and m2 both requesting continuously
      req_a[1] = 1'b1; req_a[2] = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1;
      cnt = 0; m2g = 0; cyc = 0;
      while (m2g < 2 && cyc < 100) begin
         @(negedge clk);
         if (m1_gnt) cnt++;
         if (m2_gnt) begin
            chk("starve_m1_grants_before_m2", 32'(cnt), 32'(SMAX));
            cnt = 0;
            m2g++;
         end
         tick();
         cyc++;
      end
      chk("starve_m2_grant_count", 32'(m2g), 32'h2);
      req_a[1] = 1'b0; req_a[2] = 1'b0;
      repeat (3) tick();
      s_gnt = 1'b0; s_rvalid = 1'b0;

      // timeout: slave accepts the address but never responds
      req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 32'h4000_0000;
      @(negedge clk);
      chk("to_gnt", 32'(m1_gnt), 32'h1);
      tick();
      req_a[1] = 1'b0; s_gnt = 1'b1;
      early = 0;
      for (int k = 1; k < TMO; k++) begin
         @(negedge clk);
         if (m1_rvalid || bus_err_o) early++;
         tick();
         s_gnt = 1'b0; s_rdata = 32'hBAD0_BAD0;
      end
      chk("to_no_early_abort", 32'(early), 32'h0);
      @(negedge clk);
      chk("to_rvalid", 32'(m1_rvalid), 32'h1);
      chk("to_bus_err", 32'(bus_err_o), 32'h1);
      chk("to_rdata_zero", m1_rdata, 32'h0);
      tick();
      req_a[0] = 1'b1; addr_a[0] = 32'h0000_0100; we_a[0] = 1'b0;
      @(negedge clk);
      chk("to_idle_gnt", 32'(m0_gnt), 32'h1);
      chk("to_single_pulse", 32'({m1_rvalid, bus_err_o}), 32'h0);
      tick();
      req_a[0] = 1'b0; s_gnt = 1'b1;
      tick();
      s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_ABCD;
      @(negedge clk);
      chk("to_recover_rdata", m0_rdata, 32'h0000_ABCD);
      tick();
      s_rvalid = 1'b0;

      // reset while a response is outstanding
      req_a[2] = 1'b1; addr_a[2] = 32'h5000_0000; we_a[2] = 1'b0;
      @(negedge clk);
      chk("midrst_gnt", 32'(m2_gnt), 32'h1);
      tick();
      req_a[2] = 1'b0; s_gnt = 1'b1;
      tick();
      s_gnt = 1'b0; rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("midrst_outputs_zero", 32'(any_out), 32'h0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_no_rvalid", 32'(rv_v), 32'h0);
      chk("midrst_idle_sreq", 32'(s_req), 32'h0);
      chk("midrst_idle_hold", 32'(hold_flag_o), 32'h0);
      tick();
      s_rvalid = 1'b0; req_a[1] = 1'b1; addr_a[1] = 32'h6000_0008; we_a[1] = 1'b0;
      @(negedge clk);
      chk("midrst_next_gnt", 32'(m1_gnt), 32'h1);
      tick();
      req_a[1] = 1'b0; s_gnt = 1'b1;
      @(negedge clk);
      chk("midrst_next_saddr", s_addr, 32'h6000_0008);
      tick();
      s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0123_4567;
      @(negedge clk);
      chk("midrst_next_rdata", m1_rdata, 32'h0123_4567);
      tick();
      s_rvalid = 1'b0;

      // random traffic against the reference model
      gseen = 3'b000; dead = 1'b0;
      mb_busy = 0; mb_acc = 0; mb_age = 0; mb_owner = 0; mb_starve = 0;
      mb_addr = 32'h0; mb_wdata = 32'h0; mb_we = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         rst = (i == 0 || $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         for (int n = 0; n < 3; n++) begin
            if (req_a[n] && gseen[n]) begin
               req_a[n] = 1'b0;
            end else if (!req_a[n] && $urandom_range(0, 2) == 0) begin
               req_a[n]   = 1'b1;
               we_a[n]    = 1'($urandom_range(0, 1));
               addr_a[n]  = $urandom;
               wdata_a[n] = $urandom;
            end
         end
         if (i % 48 == 0) dead = ($urandom_range(0, 3) == 0);
         s_gnt    = !dead && (1'($urandom_range(0, 1)) == 1'b1);
         s_rvalid = !dead && (1'($urandom_range(0, 1)) == 1'b1);
         s_rdata  = $urandom;
         @(negedge clk);
         model_cycle();
         gseen = gnt_v;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
